// File: rtl/tpu_pkg.sv
// Shared types and defaults for the TPU tile scheduler: controller states,
// default geometry and the tile-count helper.
package tpu_pkg;

  localparam int TPU_TILE      = 4;
  localparam int TPU_ADDR_BITS = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_HI,
    S_WAIT_LO,
    S_NEXT,
    S_FINISH
  } state_t;

  function automatic logic [7:0] ceil_div(input logic [7:0] num, input int unsigned den);
    return 8'((32'(num) + den - 32'd1) / den);
  endfunction

endpackage

// File: rtl/tpu_tile_addr_gen.sv
// Per-tile buffer base addresses and valid row/column masks, derived
// combinationally from the current tile coordinates and the latched GEMM shape.
module tpu_tile_addr_gen #(
  parameter int ADDR_BITS = 16,
  parameter int TILE      = 4
) (
  input  logic [7:0]           i_mt,
  input  logic [7:0]           i_nt,
  input  logic [7:0]           i_k,
  input  logic [7:0]           i_m,
  input  logic [7:0]           i_n,
  input  logic [7:0]           i_n_tiles,
  output logic [ADDR_BITS-1:0] o_a_base,
  output logic [ADDR_BITS-1:0] o_b_base,
  output logic [ADDR_BITS-1:0] o_c_base,
  output logic [TILE-1:0]      o_row_mask,
  output logic [TILE-1:0]      o_col_mask
);

  // Arithmetic is done at ADDR_BITS width so results wrap modulo 2**ADDR_BITS.
  always_comb begin
    o_a_base = ADDR_BITS'(i_mt) * ADDR_BITS'(i_k);
    o_b_base = ADDR_BITS'(i_nt) * ADDR_BITS'(i_k);
    o_c_base = (ADDR_BITS'(i_mt) * ADDR_BITS'(i_n_tiles) + ADDR_BITS'(i_nt))
               * ADDR_BITS'(TILE);
  end

  always_comb begin
    o_row_mask = '0;
    o_col_mask = '0;
    for (int unsigned i = 0; i < TILE; i++) begin
      o_row_mask[i] = (32'(i_mt) * 32'(TILE) + i) < 32'(i_m);
      o_col_mask[i] = (32'(i_nt) * 32'(TILE) + i) < 32'(i_n);
    end
  end

endmodule

// File: rtl/tpu_tile_sched.sv
// GEMM tile scheduler: walks output tiles row-major, launches the tile core
// once per tile and waits for its busy handshake, with a launch timeout.
module tpu_tile_sched
  import tpu_pkg::*;
#(
  parameter int ADDR_BITS      = TPU_ADDR_BITS,
  parameter int TILE           = TPU_TILE,
  parameter int LAUNCH_TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           K,
  input  logic [7:0]           M,
  input  logic [7:0]           N,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 core_in_valid,
  input  logic                 core_busy,
  output logic [7:0]           core_K,
  output logic [ADDR_BITS-1:0] A_base,
  output logic [ADDR_BITS-1:0] B_base,
  output logic [ADDR_BITS-1:0] C_base,
  output logic [TILE-1:0]      row_mask,
  output logic [TILE-1:0]      col_mask
);

  localparam int TW = $clog2(LAUNCH_TIMEOUT + 1);

  state_t        r_state;
  state_t        w_next;
  logic          r_start;
  logic [7:0]    r_K, r_M, r_N;
  logic [7:0]    r_m_tiles, r_n_tiles;
  logic [7:0]    r_mt, r_nt;
  logic [TW-1:0] r_to;
  logic          r_done, r_err, r_civ;
  logic          w_capture, w_accept, w_timeout, w_zero, w_last;

  // A start is registered together with K/M/N and acted on the following IDLE
  // cycle, giving a two-cycle start-to-launch latency like the other paths.
  assign w_capture = start && (r_state == S_IDLE) && !r_start;
  assign w_zero    = (r_K == '0) || (r_M == '0) || (r_N == '0);
  assign w_last    = (r_nt == r_n_tiles - 8'd1) && (r_mt == r_m_tiles - 8'd1);

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_timeout = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_start) begin
          w_accept = 1'b1;
          w_next   = w_zero ? S_FINISH : S_LAUNCH;
        end
      end
      S_LAUNCH:  w_next = S_WAIT_HI;
      S_WAIT_HI: begin
        if (core_busy) begin
          w_next = S_WAIT_LO;
        end else if (r_to == TW'(LAUNCH_TIMEOUT - 1)) begin
          w_timeout = 1'b1;
          w_next    = S_FINISH;
        end
      end
      S_WAIT_LO: if (!core_busy) w_next = S_NEXT;
      S_NEXT:    w_next = w_last ? S_FINISH : S_LAUNCH;
      S_FINISH:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_start   <= 1'b0;
      r_K       <= '0;
      r_M       <= '0;
      r_N       <= '0;
      r_m_tiles <= '0;
      r_n_tiles <= '0;
      r_mt      <= '0;
      r_nt      <= '0;
      r_to      <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_civ     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_start <= w_capture;
      r_done  <= (w_next == S_FINISH);
      r_civ   <= (w_next == S_LAUNCH);
      r_to    <= (r_state == S_WAIT_HI) ? r_to + TW'(1) : '0;
      if (w_capture) begin
        r_K <= K;
        r_M <= M;
        r_N <= N;
      end
      if (w_accept) begin
        r_err     <= w_zero;
        r_mt      <= '0;
        r_nt      <= '0;
        r_m_tiles <= ceil_div(r_M, TILE);
        r_n_tiles <= ceil_div(r_N, TILE);
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end
      if (r_state == S_NEXT && !w_last) begin
        if (r_nt == r_n_tiles - 8'd1) begin
          r_nt <= '0;
          r_mt <= r_mt + 8'd1;
        end else begin
          r_nt <= r_nt + 8'd1;
        end
      end
    end
  end

  tpu_tile_addr_gen #(
    .ADDR_BITS(ADDR_BITS),
    .TILE     (TILE)
  ) u_addr_gen (
    .i_mt      (r_mt),
    .i_nt      (r_nt),
    .i_k       (r_K),
    .i_m       (r_M),
    .i_n       (r_N),
    .i_n_tiles (r_n_tiles),
    .o_a_base  (A_base),
    .o_b_base  (B_base),
    .o_c_base  (C_base),
    .o_row_mask(row_mask),
    .o_col_mask(col_mask)
  );

  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign err           = r_err;
  assign core_in_valid = r_civ;
  assign core_K        = r_K;

endmodule

// File: tb/tb_tpu_tile_sched.sv
// Self-checking bench for tpu_tile_sched: directed and randomized GEMM runs
// against a tile-list model built from the tiling rules.
module tb_tpu_tile_sched;

  localparam int AB = 16;
  localparam int TL = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst, start, core_busy;
  logic [7:0]    K, M, N, core_K;
  logic          busy, done, err, core_in_valid;
  logic [AB-1:0] A_base, B_base, C_base;
  logic [TL-1:0] row_mask, col_mask;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int a;
    int b;
    int c;
    int rm;
    int cm;
  } tile_t;

  tile_t exp_q[$];

  tpu_tile_sched #(
    .ADDR_BITS     (AB),
    .TILE          (TL),
    .LAUNCH_TIMEOUT(TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .K            (K),
    .M            (M),
    .N            (N),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .core_in_valid(core_in_valid),
    .core_busy    (core_busy),
    .core_K       (core_K),
    .A_base       (A_base),
    .B_base       (B_base),
    .C_base       (C_base),
    .row_mask     (row_mask),
    .col_mask     (col_mask)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected launch sequence: row-major tiles with their bases and masks.
  function automatic void build(input int k, input int m, input int n);
    int m_t;
    int n_t;
    m_t = (m + TL - 1) / TL;
    n_t = (n + TL - 1) / TL;
    exp_q.delete();
    for (int mt = 0; mt < m_t; mt++) begin
      for (int nt = 0; nt < n_t; nt++) begin
        tile_t t;
        t.a  = (mt * k) % (1 << AB);
        t.b  = (nt * k) % (1 << AB);
        t.c  = ((mt * n_t + nt) * TL) % (1 << AB);
        t.rm = 0;
        t.cm = 0;
        for (int i = 0; i < TL; i++) begin
          if (mt * TL + i < m) t.rm |= (1 << i);
          if (nt * TL + i < n) t.cm |= (1 << i);
        end
        exp_q.push_back(t);
      end
    end
  endfunction

  task automatic check_tile(input tile_t t, input logic [7:0] k);
    chk("A_base",   32'(A_base),   32'(t.a));
    chk("B_base",   32'(B_base),   32'(t.b));
    chk("C_base",   32'(C_base),   32'(t.c));
    chk("row_mask", 32'(row_mask), 32'(t.rm));
    chk("col_mask", 32'(col_mask), 32'(t.cm));
    chk("core_K",   32'(core_K),   32'(k));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"},  32'(err),  32'd0);
    chk({tag, "_civ"},  32'(core_in_valid), 32'd0);
    chk({tag, "_A"},    32'(A_base), 32'd0);
    chk({tag, "_B"},    32'(B_base), 32'd0);
    chk({tag, "_C"},    32'(C_base), 32'd0);
    chk({tag, "_rm"},   32'(row_mask), 32'd0);
    chk({tag, "_cm"},   32'(col_mask), 32'd0);
    chk({tag, "_coreK"}, 32'(core_K), 32'd0);
  endtask

  task automatic pulse_start(input logic [7:0] k, input logic [7:0] m, input logic [7:0] n);
    K = k; M = m; N = n;
    start = 1'b1;
    step();
    start = 1'b0;
    K = 8'($urandom); M = 8'($urandom); N = 8'($urandom);
  endtask

  // Core model: random rise delay and busy length per launch; optional start
  // pulse while busy, optional reset inside tile abort_at.
  task automatic run(input logic [7:0] k, input logic [7:0] m, input logic [7:0] n,
                     input bit inject, input int abort_at);
    int dl;
    int dh;
    build(int'(k), int'(m), int'(n));
    pulse_start(k, m, n);
    chk("acc_civ", 32'(core_in_valid), 32'd0);
    chk("acc_busy", 32'(busy), 32'd0);
    step();
    for (int t = 0; t < exp_q.size(); t++) begin
      chk("launch_civ", 32'(core_in_valid), 32'd1);
      chk("launch_busy", 32'(busy), 32'd1);
      chk("launch_done", 32'(done), 32'd0);
      chk("launch_err", 32'(err), 32'd0);
      check_tile(exp_q[t], k);
      dl = $urandom_range(1, 3);
      dh = $urandom_range(1, 4);
      for (int c = 1; c <= dl + dh + 1; c++) begin
        step();
        if (t == abort_at && c == dl + 1) begin
          rst = 1'b1;
          core_busy = 1'b0;
          step();
          check_reset_outputs("abort");
          rst = 1'b0;
          for (int j = 0; j < 3; j++) begin
            step();
            chk("abort_no_done", 32'(done), 32'd0);
            chk("abort_no_civ", 32'(core_in_valid), 32'd0);
          end
          return;
        end
        chk("gap_civ", 32'(core_in_valid), 32'd0);
        chk("gap_done", 32'(done), 32'd0);
        check_tile(exp_q[t], k);
        if (c == dl) begin
          core_busy = 1'b1;
          if (inject) begin
            start = 1'b1;
            K = 8'($urandom);
          end
        end else begin
          start = 1'b0;
        end
        if (c == dl + dh) core_busy = 1'b0;
      end
      step();
    end
    chk("fin_done", 32'(done), 32'd1);
    chk("fin_err", 32'(err), 32'd0);
    chk("fin_busy", 32'(busy), 32'd1);
    chk("fin_civ", 32'(core_in_valid), 32'd0);
    step();
    chk("post_done", 32'(done), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
  endtask

  task automatic run_timeout(input logic [7:0] k, input logic [7:0] m, input logic [7:0] n);
    build(int'(k), int'(m), int'(n));
    core_busy = 1'b0;
    pulse_start(k, m, n);
    step();
    chk("to_civ", 32'(core_in_valid), 32'd1);
    check_tile(exp_q[0], k);
    for (int c = 1; c <= TO; c++) begin
      step();
      chk("to_wait_done", 32'(done), 32'd0);
      chk("to_wait_civ", 32'(core_in_valid), 32'd0);
    end
    step();
    chk("to_done", 32'(done), 32'd1);
    chk("to_err", 32'(err), 32'd1);
    step();
    chk("to_done_pulse", 32'(done), 32'd0);
    chk("to_err_sticky", 32'(err), 32'd1);
    chk("to_idle", 32'(busy), 32'd0);
  endtask

  task automatic run_zero(input logic [7:0] k, input logic [7:0] m, input logic [7:0] n);
    pulse_start(k, m, n);
    chk("zero_done_early", 32'(done), 32'd0);
    step();
    chk("zero_done", 32'(done), 32'd1);
    chk("zero_err", 32'(err), 32'd1);
    chk("zero_civ", 32'(core_in_valid), 32'd0);
    step();
    chk("zero_done_pulse", 32'(done), 32'd0);
    chk("zero_civ_after", 32'(core_in_valid), 32'd0);
    chk("zero_err_sticky", 32'(err), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rk, rm, rn;
    rst = 1'b1; start = 1'b0; core_busy = 1'b0;
    K = '0; M = '0; N = '0;
    step();
    step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    run(8'd8, 8'd4, 8'd4, 1'b0, -1);
    run(8'd4, 8'd8, 8'd12, 1'b0, -1);
    run(8'd4, 8'd6, 8'd5, 1'b0, -1);
    run(8'd255, 8'd5, 8'd9, 1'b0, -1);

    run_timeout(8'd8, 8'd4, 8'd4);
    run(8'd4, 8'd4, 8'd4, 1'b0, -1);

    run_zero(8'd4, 8'd0, 8'd4);
    run_zero(8'd0, 8'd4, 8'd4);
    run(8'd4, 8'd8, 8'd12, 1'b1, -1);

    run(8'd4, 8'd8, 8'd12, 1'b0, 2);
    run(8'd4, 8'd8, 8'd12, 1'b0, -1);

    for (int r = 0; r < 8; r++) begin
      rk = 8'($urandom_range(1, 255));
      rm = 8'($urandom_range(1, 20));
      rn = 8'($urandom_range(1, 20));
      run(rk, rm, rn, 1'($urandom_range(0, 1)), -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
